// File: rtl/lab4_mux_sel.sv
`default_nettype none
// ============================================================================
// Module   : lab4_mux_sel
// Purpose  : Registered N-channel data selector for the display path. It has
//            manual selection, freeze/hold and an optional round-robin scan.
//            The scan is compiled in by LAB4_MUX_AUTOSCAN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lab4_mux_sel #(
    parameter int WIDTH      = 16,
    parameter int CHANNELS   = 4,
    parameter int SCAN_TICKS = 100_000_000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [CHANNELS*WIDTH-1:0]     din,
    input  logic [$clog2(CHANNELS)-1:0]   sel,
    input  logic                          mode,
    input  logic                          freeze,
    output logic [WIDTH-1:0]              y,
    output logic [$clog2(CHANNELS)-1:0]   ch,
    output logic                          switched
);

    localparam int              SELW      = $clog2(CHANNELS);
    localparam logic [SELW:0]   c_NUM_CH  = (SELW+1)'(CHANNELS);
    localparam logic [SELW-1:0] c_LAST_CH = SELW'(CHANNELS - 1);

    logic [SELW-1:0]  ch_q, ch_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             switched_q, switched_d;
    logic             w_sel_valid;

    // Out-of-range requests are ignored rather than wrapped
    assign w_sel_valid = ({1'b0, sel} < c_NUM_CH);

`ifdef LAB4_MUX_AUTOSCAN_EN
    localparam int              CNTW        = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [CNTW-1:0] c_LAST_TICK = CNTW'(SCAN_TICKS - 1);

    logic [CNTW-1:0] cnt_q, cnt_d;
`else
    logic w_unused_mode;
    assign w_unused_mode = mode;
`endif

    always_comb begin
        ch_d = ch_q;
`ifdef LAB4_MUX_AUTOSCAN_EN
        cnt_d = cnt_q;
`endif
        if (!freeze) begin
`ifdef LAB4_MUX_AUTOSCAN_EN
            if (mode) begin
                if (cnt_q == c_LAST_TICK) begin
                    cnt_d = '0;
                    ch_d  = (ch_q == c_LAST_CH) ? '0 : ch_q + SELW'(1);
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end else begin
                cnt_d = '0;
                if (w_sel_valid) begin
                    ch_d = sel;
                end
            end
`else
            if (w_sel_valid) begin
                ch_d = sel;
            end
`endif
        end
    end

    // y follows the active channel every unfrozen cycle, not only on a switch
    always_comb begin
        y_d        = freeze ? y_q : din[int'(ch_d)*WIDTH +: WIDTH];
        switched_d = (ch_d != ch_q) && !freeze;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_q       <= '0;
            y_q        <= '0;
            switched_q <= 1'b0;
        end else begin
            ch_q       <= ch_d;
            y_q        <= y_d;
            switched_q <= switched_d;
        end
    end

`ifdef LAB4_MUX_AUTOSCAN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign y        = y_q;
    assign ch       = ch_q;
    assign switched = switched_q;

endmodule
`default_nettype wire

// File: doc/lab4_mux_sel.md
# lab4_mux_sel

Parametrised, registered N-channel data selector: the successor to the lab 2:1 combinational mux. It chooses one of `CHANNELS` `WIDTH`-bit sources for the display path (seven-segment or LED driver). Selection is either manual (from switches) or, when compiled in, an automatic round-robin scan with a programmable dwell time. A freeze input holds the displayed value.

## Interface
- `WIDTH`, 16, data width per channel.
- `CHANNELS`, 4, number of input channels; must be ≥2.
- `SCAN_TICKS`, 100_000_000, clock cycles each channel is shown in scan mode; must be ≥1.
- `SELW` (localparam), `$clog2(CHANNELS)`, select/channel width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `din`  in  `CHANNELS*WIDTH`  flattened sources; channel k occupies `din[k*WIDTH +: WIDTH]`.
- `sel`  in  `SELW`  manual channel request.
- `mode`  in  1  0 = manual, 1 = scan.
- `freeze`  in  1  1 = hold all outputs and internal state.
- `y`  out  `WIDTH`  registered selected data.
- `ch`  out  `SELW`  channel currently driving `y`.
- `switched`  out  1  one-cycle pulse when `ch` changes.

## Operation
- Reset (asynchronous, on `reset_n` low): `y`=0, `ch`=0, dwell counter=0, `switched`=0. Everything holds while reset is low. Outputs update on the first rising edge after release.
- Combinational `ch_next` is computed every cycle. On each edge, `ch <= ch_next` and `y <= din[ch_next]`.
- **Priority:** freeze > mode > normal update.
- **freeze=1:**
  - `ch_next = ch`.
  - `y`, `ch` and the counter hold.
  - `switched` = 0.
  - `din` changes are not reflected.
- **Manual mode (mode=0):**
  - `ch_next = sel` if `sel < CHANNELS`; otherwise `ch_next = ch`. Out-of-range requests are ignored, not wrapped.
  - The counter is held at 0.
- **Scan mode (mode=1):**
  - The counter increments each cycle.
  - When the counter equals `SCAN_TICKS-1`: counter←0 and `ch_next = (ch == CHANNELS-1) ? 0 : ch+1`. Otherwise `ch_next = ch`.
  - `sel` is ignored.
- **Mode transitions:**
  - manual→scan: scanning starts from the current `ch` with the counter at 0. The first advance occurs `SCAN_TICKS` cycles after the first scan-mode edge.
  - scan→manual: `ch_next = sel` (if valid) on the first manual edge. The counter clears.
- **Freeze release:** resumes with the held counter value. The dwell is not restarted.
- `switched` is registered: `switched <= (ch_next != ch) && !freeze`. It is high in the same cycle `ch` shows the new value.
- `y` tracks `din` of the active channel every unfrozen cycle, including cycles without a channel change.

## Timing
- `din`→`y`: 1 cycle.
- `sel`→`ch`/`y`: 1 cycle.
- `freeze` effect: the edge on which it is sampled high does not update.
- Scan period: exactly `SCAN_TICKS` cycles per channel. A full rotation takes `CHANNELS*SCAN_TICKS` cycles.
- `SCAN_TICKS`=1: `ch` advances every cycle and `switched` stays high continuously.
- Counter width: `$clog2(SCAN_TICKS)` with a minimum of 1 bit. There is no overflow; the counter is compared and cleared at `SCAN_TICKS-1`.
- No combinational path from inputs to outputs.

## Configuration
- Macro `LAB4_MUX_AUTOSCAN_EN`.
- **Defined:** scan mode and the dwell counter are implemented as above.
- **Undefined:** the counter is not instantiated and `mode` is ignored. The block always behaves as manual mode, with freeze and `switched` unchanged and the port list identical.

## Test plan
Bench parameters: `WIDTH`=16, `CHANNELS`=3, `SCAN_TICKS`=4, channel data `din`={16'hCCCC, 16'hBBBB, 16'hAAAA} (ch0=AAAA).

- **Reset:** assert `reset_n`=0 mid-run with `ch`=2 → `y`=0, `ch`=0, `switched`=0 immediately, before the next edge. Release with `sel`=0 → first edge `y`=AAAA.
- **Manual select:** `sel`=1 → next edge `y`=BBBB, `ch`=1, `switched`=1 for one cycle. Then `sel`=3 (out of range) → `ch` stays 1, `switched`=0.
- **Scan (macro defined):** `mode`=1 from `ch`=0 → `ch` sequence 0,0,0,0,1,1,1,1,2,…,2,0. `switched` pulses once per 4 cycles, and the wrap 2→0 occurs after 12 cycles.
- **Freeze:**
  - Freeze in scan at counter=2 with `ch`=1, holding 5 cycles while ch1 changes to 1234 → `y` stays BBBB and `ch` stays 1.
  - Release → advance to `ch`=2 after 2 more cycles.
- **Scan→manual:** `mode`=0 with `sel`=0 while `ch`=2 → next edge `ch`=0, `y`=AAAA, `switched`=1.
- **Macro undefined:** `mode`=1 with `sel` held at 2 for 20 cycles → `ch` constant 2, `switched` never pulses.
